weight_mem_stream: RTL and testbench

- Parametrised, writable successor to the per-neuron fixed-ROM weight memories.
- Each instance holds the weights of one neuron (layer LAYER_NO, neuron NEURON_NO) in a block-RAM array.
- Weights are loaded at runtime through a shared broadcast write bus, selected by layer/neuron match.
- On a start pulse, the block streams all NUM_WEIGHTS words in address order to the neuron MAC, with valid/last flags and a hold (stall) input.

---
 rtl/weight_mem_stream.sv | 161 ++++++++++++++++
 tb/tb_weight_mem_stream.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/weight_mem_stream.sv
// Runtime-loadable weight memory for one neuron; streams all weights to the MAC on start.
// Define WMEM_OUTREG_EN for an extra output register stage (2-cycle read latency).
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_READ  | issuing one read per non-held cycle
//   S_DRAIN | all reads issued, waiting for the wlast beat to be consumed
module weight_mem_stream #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int NUM_WEIGHTS = 784,
  parameter int LAYER_NO    = 1,
  parameter int NEURON_NO   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wen,
  input  logic [7:0]            cfg_layer,
  input  logic [15:0]           cfg_neuron,
  input  logic [DATA_WIDTH-1:0] cfg_wdata,
  input  logic                  cfg_wclr,
  output logic                  load_done,
  input  logic                  start,
  input  logic                  hold,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] wout,
  output logic                  wvalid,
  output logic                  wlast
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WEIGHTS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [7:0]            LAYER_ID  = 8'(LAYER_NO);
  localparam logic [15:0]           NEURON_ID = 16'(NEURON_NO);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic                    load_done_q, load_done_d;
  logic                    wr_acc;
  logic                    rd_issue;
  logic [DATA_WIDTH-1:0]   s1_data_q;
  logic                    s1_valid_q, s1_last_q;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_valid, out_last;

  // Clear beats a coincident write, so the write is simply not accepted.
  assign wr_acc = cfg_wen && !cfg_wclr && (cfg_layer == LAYER_ID) && (cfg_neuron == NEURON_ID);

  always_comb begin
    wptr_d      = wptr_q;
    load_done_d = load_done_q;
    if (cfg_wclr) begin
      wptr_d      = '0;
      load_done_d = 1'b0;
    end else if (wr_acc) begin
      if (wptr_q == LAST_ADDR) begin
        wptr_d      = '0;
        load_done_d = 1'b1;
      end else begin
        wptr_d = wptr_q + ADDR_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      load_done_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      load_done_q <= load_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr_q] <= cfg_wdata;
  end

  always_comb begin
    state_d  = state_q;
    raddr_d  = raddr_q;
    rd_issue = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          raddr_d = '0;
        end
      end
      S_READ: begin
        if (!hold) begin
          rd_issue = 1'b1;
          raddr_d  = raddr_q + ADDR_ONE;
          if (raddr_q == LAST_ADDR) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_valid && out_last && !hold) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
    end
  end

  // Non-blocking read alongside the write above gives read-first behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else if (!hold) begin
      s1_valid_q <= rd_issue;
      s1_last_q  <= rd_issue && (raddr_q == LAST_ADDR);
      if (rd_issue) s1_data_q <= mem[raddr_q];
    end
  end

`ifdef WMEM_OUTREG_EN
  logic [DATA_WIDTH-1:0] s2_data_q;
  logic                  s2_valid_q, s2_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
    end else if (!hold) begin
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      if (s1_valid_q) s2_data_q <= s1_data_q;
    end
  end

  assign out_data  = s2_data_q;
  assign out_valid = s2_valid_q;
  assign out_last  = s2_last_q;
`else
  assign out_data  = s1_data_q;
  assign out_valid = s1_valid_q;
  assign out_last  = s1_last_q;
`endif

  assign wout      = out_data;
  assign wvalid    = out_valid;
  assign wlast     = out_last;
  assign busy      = (state_q != S_IDLE);
  assign load_done = load_done_q;

endmodule

// File: tb/tb_weight_mem_stream.sv
// Directed bench for weight_mem_stream: load, stream, backpressure, overwrite, clear, reset mid-pass.
module tb_weight_mem_stream;

`ifdef WMEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NUM = 784;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wen;
  logic [7:0]  cfg_layer;
  logic [15:0] cfg_neuron;
  logic [15:0] cfg_wdata;
  logic        cfg_wclr;
  logic        load_done;
  logic        start;
  logic        hold;
  logic        busy;
  logic [15:0] wout;
  logic        wvalid;
  logic        wlast;

  logic [15:0] exp_mem [NUM];
  int n_checks = 0;
  int n_err    = 0;

  weight_mem_stream dut (
    .clk(clk), .rst(rst),
    .cfg_wen(cfg_wen), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
    .cfg_wdata(cfg_wdata), .cfg_wclr(cfg_wclr), .load_done(load_done),
    .start(start), .hold(hold), .busy(busy),
    .wout(wout), .wvalid(wvalid), .wlast(wlast)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wr(input logic [7:0] layer, input logic [15:0] neuron,
                    input logic [15:0] data, input logic clr);
    cfg_wen    = 1'b1;
    cfg_layer  = layer;
    cfg_neuron = neuron;
    cfg_wdata  = data;
    cfg_wclr   = clr;
    tick();
    cfg_wen  = 1'b0;
    cfg_wclr = 1'b0;
  endtask

  // One streaming pass; hold_beat stalls that beat 3 cycles, abort_beat resets
  // when that beat is presented, do_ow writes 0xABCD to address 0 as it is read.
  task automatic run_pass(input string nm, input int hold_beat, input int abort_beat, input bit do_ow);
    int idx, cyc, held, first_cyc, last_cyc;
    idx = 0; cyc = 0; held = 0; first_cyc = -1; last_cyc = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({nm, "_busy_rise"}, busy, 1);
    chk({nm, "_no_early_valid"}, wvalid, 0);
    if (do_ow) begin
      cfg_wen = 1'b1; cfg_layer = 8'd1; cfg_neuron = 16'd0; cfg_wdata = 16'hABCD;
    end
    while (idx < NUM && cyc < 4000) begin
      tick();
      cyc++;
      cfg_wen = 1'b0;
      if (!wvalid) begin
        if (first_cyc >= 0) chk({nm, "_gap"}, wvalid, 1);
      end else begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          chk({nm, "_latency"}, cyc, LAT);
        end
        if (idx == abort_beat) begin
          chk({nm, "_abort_word"}, wout, exp_mem[idx]);
          rst = 1'b1;
          #1;
          chk({nm, "_rst_busy"}, busy, 0);
          chk({nm, "_rst_wvalid"}, wvalid, 0);
          chk({nm, "_rst_wlast"}, wlast, 0);
          chk({nm, "_rst_wout"}, wout, 0);
          chk({nm, "_rst_load_done"}, load_done, 0);
          tick();
          rst = 1'b0;
          return;
        end
        if (idx == hold_beat && held < 3) begin
          hold = 1'b1;
          held++;
          chk({nm, "_held_word"}, wout, exp_mem[idx]);
          chk({nm, "_held_wlast"}, wlast, 0);
        end else begin
          hold = 1'b0;
          chk({nm, "_word"}, wout, exp_mem[idx]);
          chk({nm, "_wlast"}, wlast, (idx == NUM - 1) ? 1 : 0);
          if (idx == NUM - 1) chk({nm, "_busy_on_last"}, busy, 1);
          last_cyc = cyc;
          idx++;
        end
      end
    end
    hold = 1'b0;
    chk({nm, "_beat_count"}, idx, NUM);
    if (hold_beat < 0) chk({nm, "_span"}, last_cyc - first_cyc, NUM - 1);
    tick();
    chk({nm, "_busy_drop"}, busy, 0);
    chk({nm, "_wvalid_drop"}, wvalid, 0);
    chk({nm, "_wlast_drop"}, wlast, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cfg_wen = 1'b0; cfg_layer = '0; cfg_neuron = '0; cfg_wdata = '0;
    cfg_wclr = 1'b0; start = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_wvalid", wvalid, 0);
    chk("reset_wlast", wlast, 0);
    chk("reset_wout", wout, 0);
    chk("reset_load_done", load_done, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NUM; i++) begin
      exp_mem[i] = 16'(i);
      wr(8'd1, 16'd0, 16'(i), 1'b0);
      if (i == 9) begin
        wr(8'd1, 16'd1, 16'hDEAD, 1'b0);
        wr(8'd2, 16'd0, 16'hBEEF, 1'b0);
      end
      if (i == NUM - 2) chk("load_done_before_last", load_done, 0);
    end
    chk("load_done_after_last", load_done, 1);

    run_pass("p1", -1, -1, 1'b0);
    run_pass("p2", 5, -1, 1'b1);
    exp_mem[0] = 16'hABCD;
    chk("load_done_after_overwrite", load_done, 1);
    run_pass("p3", -1, -1, 1'b0);

    wr(8'd1, 16'd0, 16'h1111, 1'b1);
    chk("wclr_load_done", load_done, 0);
    wr(8'd1, 16'd0, 16'h2222, 1'b0);
    exp_mem[0] = 16'h2222;
    chk("post_clr_load_done", load_done, 0);
    run_pass("p4", -1, -1, 1'b0);

    run_pass("p5", -1, 100, 1'b0);
    run_pass("p6", -1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
